// File: rtl/pad_in_conditioner.sv
// rtl/pad_in_conditioner.sv - per-pad input synchronizer, glitch filter and edge/level interrupt detector
// Glitch filter counters are compiled in only when PAD_IN_FILTER_EN is defined.
module pad_in_conditioner #(
  parameter int N_IO  = 48,
  parameter int CNT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_IO-1:0]   io_in_i,
  input  logic [N_IO-1:0]   filt_en_i,
  input  logic [CNT_W-1:0]  filt_len_i,
  input  logic [2*N_IO-1:0] irq_type_i,
  input  logic [N_IO-1:0]   irq_en_i,
  input  logic [N_IO-1:0]   irq_clr_i,
  output logic [N_IO-1:0]   data_o,
  output logic [N_IO-1:0]   irq_pending_o,
  output logic              irq_o
);

  logic [N_IO-1:0] s1, s2;
  logic [N_IO-1:0] data_nxt;
  logic [N_IO-1:0] event_hit;
  logic [N_IO-1:0] pending_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_in_i;
      s2 <= s1;
    end
  end

`ifdef PAD_IN_FILTER_EN
  logic [CNT_W-1:0] cnt_q   [N_IO];
  logic [CNT_W-1:0] cnt_nxt [N_IO];

  // cnt counts consecutive cycles s2 has disagreed with data_o; >= lets a shortened L release at once
  always_comb begin
    data_nxt = data_o;
    for (int k = 0; k < N_IO; k++) begin
      cnt_nxt[k] = '0;
      if (!filt_en_i[k]) begin
        data_nxt[k] = s2[k];
      end else if (s2[k] != data_o[k]) begin
        if (cnt_q[k] >= filt_len_i) begin
          data_nxt[k] = s2[k];
        end else begin
          cnt_nxt[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_IO; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_IO; k++) cnt_q[k] <= cnt_nxt[k];
    end
  end
`else
  logic unused_filter_cfg;
  assign unused_filter_cfg = ^{filt_en_i, filt_len_i};
  assign data_nxt = s2;
`endif

  // Events look at the value data_o is about to take so pending rises with data_o
  always_comb begin
    event_hit = '0;
    for (int k = 0; k < N_IO; k++) begin
      case (irq_type_i[2*k +: 2])
        2'b00:   event_hit[k] = ~data_o[k] &  data_nxt[k];
        2'b01:   event_hit[k] =  data_o[k] & ~data_nxt[k];
        2'b10:   event_hit[k] =  data_o[k] ^  data_nxt[k];
        default: event_hit[k] =  data_nxt[k];
      endcase
    end
  end

  assign pending_nxt = event_hit | (irq_pending_o & ~irq_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o        <= '0;
      irq_pending_o <= '0;
      irq_o         <= 1'b0;
    end else begin
      data_o        <= data_nxt;
      irq_pending_o <= pending_nxt;
      irq_o         <= |(irq_pending_o & irq_en_i);
    end
  end

endmodule
